// File: rtl/v_mul_seq.sv
// Sequencer for the SIMD vector multiplier: issues register-file reads, tracks
// products through the fixed multiplier latency and retires masked writes.
//
// state    | meaning
// S_IDLE   | waiting for start; latches the command
// S_ISSUE  | one read per cycle, word 0..nwords-1
// S_DRAIN  | reads finished, waiting for the last write to retire
// S_DONE   | one-cycle done (and err) pulse
module v_mul_seq #(
  parameter int MUL_LAT = 3,
  parameter int ADDR_W  = 5,
  parameter int VL_W    = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        sew_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [ADDR_W-1:0] vs1_addr_i,
  input  logic [ADDR_W-1:0] vs2_addr_i,
  input  logic [ADDR_W-1:0] vd_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  input  logic [31:0]       rd_data_a_i,
  input  logic [31:0]       rd_data_b_i,
  output logic [31:0]       mul_op_a_o,
  output logic [31:0]       mul_op_b_o,
  output logic [2:0]        mul_sew_o,
  output logic              mul_is_mul_o,
  input  logic [31:0]       mul_result_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_be_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [2:0]        sew_q;
  logic [ADDR_W-1:0] vs1_q, vs2_q, vd_q;
  logic [VL_W-1:0]   last_q;
  logic [3:0]        tail_be_q;
  logic [VL_W-1:0]   idx_q;
  logic [VL_W-1:0]   rem_q;
  logic              err_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [VL_W-1:0]   rd_idx_q;
  logic [3:0]        rd_be_q;

  // Issue-tracking pipe: stage 0 lines up with the operands, stage MUL_LAT with the result.
  logic              pv_q   [MUL_LAT+1];
  logic [VL_W-1:0]   pidx_q [MUL_LAT+1];
  logic [3:0]        pbe_q  [MUL_LAT+1];

  logic [VL_W:0]     vl_p1, vl_p3;
  logic [VL_W-1:0]   nwords_c;
  logic [3:0]        tail_be_c;

  always_comb begin
    vl_p1     = {1'b0, vl_i} + (VL_W+1)'(1);
    vl_p3     = {1'b0, vl_i} + (VL_W+1)'(3);
    nwords_c  = vl_i;
    tail_be_c = 4'hF;
    case (sew_i)
      3'd0: begin
        nwords_c = VL_W'(vl_p3 >> 2);
        case (vl_i[1:0])
          2'd1:    tail_be_c = 4'h1;
          2'd2:    tail_be_c = 4'h3;
          2'd3:    tail_be_c = 4'h7;
          default: tail_be_c = 4'hF;
        endcase
      end
      3'd1: begin
        nwords_c  = VL_W'(vl_p1 >> 1);
        tail_be_c = vl_i[0] ? 4'h3 : 4'hF;
      end
      default: begin
        nwords_c  = vl_i;
        tail_be_c = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sew_q       <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      last_q      <= '0;
      tail_be_q   <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rd_idx_q    <= '0;
      rd_be_q     <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        pv_q[k]   <= 1'b0;
        pidx_q[k] <= '0;
        pbe_q[k]  <= '0;
      end
    end else begin
      rd_en_q   <= 1'b0;
      pv_q[0]   <= rd_en_q;
      pidx_q[0] <= rd_idx_q;
      pbe_q[0]  <= rd_be_q;
      for (int k = 1; k <= MUL_LAT; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
        pbe_q[k]  <= pbe_q[k-1];
      end

      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start_i) begin
            sew_q     <= sew_i;
            vs1_q     <= vs1_addr_i;
            vs2_q     <= vs2_addr_i;
            vd_q      <= vd_addr_i;
            last_q    <= nwords_c - VL_W'(1);
            tail_be_q <= tail_be_c;
            if (sew_i > 3'd2) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (vl_i == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q     <= S_ISSUE;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= vs1_addr_i;
              rd_addr_b_q <= vs2_addr_i;
              rd_idx_q    <= '0;
              rd_be_q     <= (nwords_c == VL_W'(1)) ? tail_be_c : 4'hF;
              idx_q       <= VL_W'(1);
              rem_q       <= nwords_c - VL_W'(1);
            end
          end
        end
        S_ISSUE: begin
          // rem_q counts reads still to issue after the one on the bus this cycle
          if (rem_q == '0) begin
            state_q <= S_DRAIN;
          end else begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= vs1_q + ADDR_W'(idx_q);
            rd_addr_b_q <= vs2_q + ADDR_W'(idx_q);
            rd_idx_q    <= idx_q;
            rd_be_q     <= (rem_q == VL_W'(1)) ? tail_be_q : 4'hF;
            idx_q       <= idx_q + VL_W'(1);
            rem_q       <= rem_q - VL_W'(1);
          end
        end
        S_DRAIN: begin
          if (pv_q[MUL_LAT] && (pidx_q[MUL_LAT] == last_q)) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_DONE) && err_q;
  assign rd_en_o      = rd_en_q;
  assign rd_addr_a_o  = rd_addr_a_q;
  assign rd_addr_b_o  = rd_addr_b_q;
  assign mul_op_a_o   = pv_q[0] ? rd_data_a_i : 32'h0;
  assign mul_op_b_o   = pv_q[0] ? rd_data_b_i : 32'h0;
  assign mul_sew_o    = busy_o ? sew_q : 3'd0;
  assign mul_is_mul_o = busy_o;
  assign wr_en_o      = pv_q[MUL_LAT];
  assign wr_addr_o    = pv_q[MUL_LAT] ? (vd_q + ADDR_W'(pidx_q[MUL_LAT])) : '0;
  assign wr_data_o    = pv_q[MUL_LAT] ? mul_result_i : 32'h0;
  assign wr_be_o      = pv_q[MUL_LAT] ? pbe_q[MUL_LAT] : 4'h0;

endmodule

// File: tb/tb_v_mul_seq.sv
// Self-checking bench for v_mul_seq with register-file and multiplier models
// and a write scoreboard keyed on expected cycle, address, data and byte enables.
module tb_v_mul_seq;
  localparam int MUL_LAT = 3;
  localparam int ADDR_W  = 5;
  localparam int VL_W    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        sew = '0;
  logic [VL_W-1:0]   vl = '0;
  logic [ADDR_W-1:0] vs1 = '0, vs2 = '0, vd = '0;
  logic              busy, done, err, rd_en, mul_is_mul, wr_en;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [31:0]       rd_data_a = '0, rd_data_b = '0;
  logic [31:0]       mul_op_a, mul_op_b, mul_result, wr_data;
  logic [2:0]        mul_sew;
  logic [3:0]        wr_be;

  v_mul_seq #(.MUL_LAT(MUL_LAT), .ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sew_i(sew), .vl_i(vl),
    .vs1_addr_i(vs1), .vs2_addr_i(vs2), .vd_addr_i(vd),
    .busy_o(busy), .done_o(done), .err_o(err),
    .rd_en_o(rd_en), .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b),
    .mul_op_a_o(mul_op_a), .mul_op_b_o(mul_op_b), .mul_sew_o(mul_sew),
    .mul_is_mul_o(mul_is_mul), .mul_result_i(mul_result),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s);
    logic [31:0] r;
    r = '0;
    case (s)
      3'd0: for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(a[8*i +: 8] * b[8*i +: 8]);
      3'd1: for (int i = 0; i < 2; i++) r[16*i +: 16] = 16'(a[16*i +: 16] * b[16*i +: 16]);
      3'd2: r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Register file: read data one cycle after rd_en.
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  // Multiplier: result MUL_LAT cycles after operands.
  logic [31:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= mul_model(mul_op_a, mul_op_b, mul_sew);
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_result = mp[MUL_LAT-1];

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;
  wr_t sb[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) rd_cnt++;
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk("wr_unexpected", {31'b0, wr_en}, 32'h0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
          chk("wr_data", wr_data, e.data);
          chk("wr_be", {28'b0, wr_be}, {28'b0, e.be});
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk(tag, {26'b0, busy, done, err, rd_en, wr_en, mul_is_mul}, 32'h0);
    chk({tag, "_bus"}, mul_op_a | mul_op_b | wr_data | 32'(rd_addr_a) | 32'(rd_addr_b)
                       | 32'(wr_addr) | 32'(wr_be) | 32'(mul_sew), 32'h0);
  endtask

  task automatic run_cmd(input logic [2:0] s, input int n, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] d, input bit poke);
    int t0, epw, nw, r, exp_done, k;
    logic [3:0] be;
    wr_t e;
    @(negedge clk);
    start = 1'b1; sew = s; vl = VL_W'(n); vs1 = a1; vs2 = a2; vd = d;
    t0 = cyc;
    rd_cnt = 0;
    epw = (s == 3'd0) ? 4 : (s == 3'd1) ? 2 : 1;
    nw  = (s <= 3'd2) ? (n + epw - 1) / epw : 0;
    r   = n % epw;
    for (int i = 0; i < nw; i++) begin
      be = 4'hF;
      if (i == nw - 1 && r != 0) be = (s == 3'd0) ? 4'((1 << r) - 1) : 4'h3;
      e.cyc  = t0 + 2 + i + MUL_LAT;
      e.addr = 5'(d + i);
      e.data = mul_model(mem_a[5'(a1 + i)], mem_b[5'(a2 + i)], s);
      e.be   = be;
      sb.push_back(e);
    end
    exp_done = (nw == 0) ? t0 + 1 : t0 + nw + 2 + MUL_LAT;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", {31'b0, busy}, 32'h1);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      start = poke && (cyc == t0 + 2);
    end
    if (k >= 300) chk("done_timeout", {31'b0, done}, 32'h1);
    chk("done_cycle", cyc, exp_done);
    chk("err", {31'b0, err}, {31'b0, (s > 3'd2)});
    chk("busy_done", {31'b0, busy}, 32'h1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", {31'b0, busy}, 32'h0);
    chk("done_pulse", {31'b0, done}, 32'h0);
    repeat (MUL_LAT + 2) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("wr_left", sb.size(), 0);
    chk("rd_count", rd_cnt, nw);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    mem_a[0] = 32'h1003FF02;
    mem_b[8] = 32'h1005FF07;
    mem_a[4] = 32'h00010000;
    mem_b[5] = 32'h00030000;

    repeat (3) @(negedge clk);
    check_quiet("reset_outs");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd(3'd0, 10, 5'd0, 5'd8, 5'd16, 1'b0);   // 8-bit tail
    run_cmd(3'd2, 1, 5'd4, 5'd5, 5'd20, 1'b0);    // 32-bit single element
    run_cmd(3'd0, 0, 5'd1, 5'd2, 5'd3, 1'b0);     // zero length
    run_cmd(3'd3, 5, 5'd1, 5'd2, 5'd3, 1'b0);     // illegal width
    run_cmd(3'd1, 3, 5'd2, 5'd10, 5'd3, 1'b1);    // start while busy

    // reset in cycle 3 of a long command
    @(negedge clk);
    start = 1'b1; sew = 3'd0; vl = VL_W'(64); vs1 = 5'd0; vs2 = 5'd0; vd = 5'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check_quiet("midop_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_cnt = 0;
    repeat (24) @(negedge clk);
    chk("post_reset_busy", {31'b0, busy}, 32'h0);
    chk("post_reset_reads", rd_cnt, 0);

    run_cmd(3'd0, 7, 5'd3, 5'd9, 5'd12, 1'b0);    // normal run after reset
    run_cmd(3'd2, 2, 5'd6, 5'd7, 5'd31, 1'b0);    // write address wrap
    run_cmd(3'd1, 7, 5'd30, 5'd29, 5'd2, 1'b0);   // read address wrap, 16-bit tail
    run_cmd(3'd0, 64, 5'd0, 5'd16, 5'd8, 1'b0);   // maximum vl
    run_cmd(3'd2, 5, 5'd11, 5'd12, 5'd13, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/v_mul_seq.md
# v_mul_seq

Sequencer for the SIMD vector multiplier in the vector coprocessor execute stage. It accepts one vector-multiply command (`sew`, `vl`, register base addresses), then streams source words from the vector register file read port into the multiplier at one word per cycle. It tracks in-flight products through the multiplier's fixed pipeline latency and writes results back with a tail byte mask. It raises `done` when the last write retires.

## Interface
Parameters:
- `MUL_LAT`, default 3: multiplier latency in cycles, from operands presented to `mul_result` valid.
- `ADDR_W`, default 5: vector register file word-address width.
- `VL_W`, default 7: width of `vl`. Maximum `vl` is 64.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: command strobe, sampled only in IDLE.
- `sew`  in  3: element width. 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, others illegal.
- `vl`  in  VL_W: element count.
- `vs1_addr`, `vs2_addr`, `vd_addr`  in  ADDR_W each: word base addresses.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle pulse alongside `done` for an illegal `sew`.
- `rd_en`  out  1: register file read strobe.
- `rd_addr_a`, `rd_addr_b`  out  ADDR_W: read addresses.
- `rd_data_a`, `rd_data_b`  in  32: read data, valid the cycle after `rd_en`.
- `mul_op_a`, `mul_op_b`  out  32: multiplier operands.
- `mul_sew`  out  3: multiplier element width.
- `mul_is_mul`  out  1: multiplier enable.
- `mul_result`  in  32: packed lane products, low bits of each lane.
- `wr_en`  out  1: register file write strobe.
- `wr_addr`  out  ADDR_W: write address.
- `wr_data`  out  32: write data.
- `wr_be`  out  4: write byte enables.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - When `start`=1, latch `sew`, `vl` and the three addresses.
  - If `sew`>2, go to DONE with `err` flagged.
  - Else if `vl`=0, go to DONE; no reads or writes are issued.
  - Else go to ISSUE.
- Elements per word: epw = 4, 2, 1 for `sew` = 0, 1, 2.
- Word count: nwords = ceil(vl/epw).
- ISSUE
  - Assert `rd_en` every cycle for word i = 0..nwords-1.
  - `rd_addr_a` = vs1_addr+i and `rd_addr_b` = vs2_addr+i, modulo 2^ADDR_W (wraps).
  - After the last read, go to DRAIN.
- Issue-tracking pipe: MUL_LAT+1 stages, each holding valid, word index and byte enables. A stage is pushed every cycle, with valid=0 when no read was issued.
- Operands
  - In the cycle after a read, drive `mul_op_a`/`mul_op_b` = `rd_data_a`/`rd_data_b`.
  - Otherwise drive the operands to 0.
  - `mul_sew` = latched `sew` and `mul_is_mul` = 1 while `busy`; both are 0 otherwise.
- Write-back: when the pipe output is valid, drive `wr_en`=1, `wr_addr` = vd_addr+i (wrapping), `wr_data` = `mul_result`, and `wr_be` from that stage.
- Byte enables
  - All words except the last: 4'b1111.
  - Last word, r = vl mod epw ≠ 0:
    - `sew`=0: `wr_be` = (1<<r)-1.
    - `sew`=1 (r=1): `wr_be` = 4'b0011.
- DRAIN: move to DONE in the cycle after the final write.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `start` is ignored in every state except IDLE, including the DONE cycle.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE. All latches and pipe stages are cleared.
- Reset during a command (asserted at any cycle):
  - The command is aborted immediately.
  - In-flight products are discarded; no write or `done` follows.
- Per-cycle schedule, with `start` accepted in cycle 0:
  - `rd_en` for word i in cycle 1+i.
  - Operands for word i present in cycle 2+i.
  - Write of word i in cycle 2+i+MUL_LAT.
  - `done` in cycle nwords+2+MUL_LAT.
- `vl`=0 or illegal `sew`: `done` (and `err` if applicable) in cycle 1, with `busy`=1 in cycle 1 only.
- `busy` is 1 from cycle 1 through the DONE cycle inclusive, and 0 afterwards.
- Throughput: one word per cycle, no bubbles. Write-back is never stalled.

## Test plan
- 8-bit tail:
  - Stimulus: MUL_LAT=3, `sew`=0, `vl`=10, vs1=0, vs2=8, vd=16; word0 a=0x1003FF02, b=0x1005FF07.
  - Response: reads in cycles 1–3; writes to 16/17/18 in cycles 5/6/7 with `wr_be` = F/F/3.
  - Word0 `wr_data` = 0x000F010E; `done` in cycle 8.
- 32-bit single element:
  - Stimulus: `sew`=2, `vl`=1, a=0x00010000, b=0x00030000.
  - Response: one write with `wr_data`=0x00000000 and `wr_be`=F; `done` in cycle 6.
- Zero length:
  - Stimulus: `vl`=0.
  - Response: no `rd_en` or `wr_en`; `done`=1 and `err`=0 in cycle 1; `busy` high only in cycle 1.
- Illegal width:
  - Stimulus: `sew`=3, `vl`=5.
  - Response: `done`=1 and `err`=1 in cycle 1; no accesses.
- Start while busy:
  - Stimulus: `start` pulsed in cycle 2 and again in the DONE cycle of an `sew`=1, `vl`=3 command.
  - Response: both pulses ignored; exactly 2 writes, with the second `wr_be`=3.
- Reset mid-operation:
  - Stimulus: `rst` asserted in cycle 3 of an `sew`=0, `vl`=64 command.
  - Response: all outputs 0 at once; no writes after release; a new `start` then runs normally.
- Address wrap:
  - Stimulus: vd=31, `sew`=2, `vl`=2.
  - Response: writes go to addresses 31 then 0.
